// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: word-side handshake of the parametrised UART receiver.
// master = receiver (presents the word and status), slave = consumer (rx_ready).
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with internal sample-tick divider,
// 3-sample majority vote, false-start rejection, framing/overrun detection and
// a valid/ready word handshake.
// Optional parity bit: define UART_RX_PARITY_EN to insert a PARITY state after
// the data bits; otherwise parity_err is tied to 0.
module uart_rx_param #(
    parameter int CLK_DIV    = 25,  // clk cycles per sample tick (>=2)
    parameter int OVERSAMPLE = 16,  // sample ticks per bit (even, >=8)
    parameter int DATA_BITS  = 8,   // 5..9, LSB first
    parameter int STOP_BITS  = 1,   // 1 or 2
    parameter int PARITY_ODD = 0    // 0 = even, 1 = odd
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    uart_rx_param_if.master bus
);
    localparam int M     = OVERSAMPLE / 2;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [S_W-1:0]   S_VOTE0  = S_W'(M - 1);
    localparam logic [S_W-1:0]   S_VOTE1  = S_W'(M);
    localparam logic [S_W-1:0]   S_DECIDE = S_W'(M + 1);
    localparam logic [S_W-1:0]   S_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]   S_ONE    = S_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             PAR_SENSE = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_reg;
    logic                 sync1_reg;
    logic                 rx_s_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [S_W-1:0]       s_reg;
    logic                 vote0_reg;
    logic                 vote1_reg;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 ferr_acc_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 ferr_reg;
    logic                 overrun_reg;

    logic tick;
    logic start_det;
    logic vote;
    logic at_decide;
    logic at_end;
    logic complete;
    logic ferr_new;

    assign tick      = (div_reg == DIV_LAST);
    assign start_det = (state_reg == ST_IDLE) && !rx_s_reg;
    // Majority of the samples at s=M-1, s=M and the live sample at s=M+1.
    assign vote      = (vote0_reg & vote1_reg) | (vote0_reg & rx_s_reg) | (vote1_reg & rx_s_reg);
    assign at_decide = tick && (s_reg == S_DECIDE);
    assign at_end    = tick && (s_reg == S_LAST);
    // The frame completes at the vote of the last stop bit, not at its end,
    // so a back-to-back start edge is never missed.
    assign complete  = (state_reg == ST_STOP) && at_decide && (stop_cnt_reg == STOP_LAST);
    assign ferr_new  = ferr_acc_reg | ~vote;

    // Two-flop synchronizer for the asynchronous serial line, idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            rx_s_reg  <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rx_s_reg  <= sync1_reg;
        end
    end

    // Sample-tick divider, re-phased on every start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (start_det || tick) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DIV_ONE;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg;
    logic perr_reg;
    logic perr_new;

    // Received parity bit disagrees with the data XOR (inverted for odd parity).
    assign perr_new       = par_bit_reg ^ (^shift_reg) ^ PAR_SENSE;
    assign bus.parity_err = perr_reg;

    // Parity bit capture and its error flag, loaded together with the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit_reg <= 1'b0;
            perr_reg    <= 1'b0;
        end else begin
            if ((state_reg == ST_PARITY) && at_decide) begin
                par_bit_reg <= vote;
            end
            if (complete && (!valid_reg || bus.rx_ready)) begin
                perr_reg <= perr_new;
            end
        end
    end
`else
    // No parity bit on the line, so the parity sense has nothing to act on.
    assign bus.parity_err = PAR_SENSE & 1'b0;
`endif

    // Frame FSM plus the registered word/handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            s_reg        <= '0;
            vote0_reg    <= 1'b0;
            vote1_reg    <= 1'b0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            shift_reg    <= '0;
            ferr_acc_reg <= 1'b0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            ferr_reg     <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;

            if (state_reg == ST_IDLE) begin
                s_reg <= '0;
            end else if (tick) begin
                s_reg <= (s_reg == S_LAST) ? '0 : s_reg + S_ONE;
            end
            if (tick && (s_reg == S_VOTE0)) begin
                vote0_reg <= rx_s_reg;
            end
            if (tick && (s_reg == S_VOTE1)) begin
                vote1_reg <= rx_s_reg;
            end

            case (state_reg)
                ST_IDLE: begin
                    ferr_acc_reg <= 1'b0;
                    if (!rx_s_reg) begin
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (at_decide && vote) begin
                        state_reg <= ST_IDLE;
                    end else if (at_end) begin
                        state_reg   <= ST_DATA;
                        bit_cnt_reg <= '0;
                    end
                end
                ST_DATA: begin
                    if (at_decide) begin
                        shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        if (bit_cnt_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                            stop_cnt_reg <= 1'b0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (at_end) begin
                        state_reg    <= ST_STOP;
                        stop_cnt_reg <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (at_decide) begin
                        if (stop_cnt_reg == STOP_LAST) begin
                            state_reg <= vote ? ST_IDLE : ST_BREAK;
                        end else begin
                            ferr_acc_reg <= ferr_new;
                        end
                    end
                    if (at_end) begin
                        stop_cnt_reg <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s_reg) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (complete) begin
                if (!valid_reg || bus.rx_ready) begin
                    data_reg  <= shift_reg;
                    ferr_reg  <= ferr_new;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && bus.rx_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_valid  = valid_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.busy      = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames into uart_rx_param (default parameters,
// 400 clk per bit). Expected words go into a queue; a monitor pops and
// compares every word the receiver presents.
module tb_uart_rx_param;
    localparam int BIT_CLK = 400;
`ifdef UART_RX_PARITY_EN
    localparam logic PE_07_BAD = 1'b1;
`else
    localparam logic PE_07_BAD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx = 1'b1;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_prev_valid = 1'b0;
    logic mon_prev_hs = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_cnt = 0;
    int   word_cnt = 0;
    int   push_cnt = 0;
    int   ovr0;
    int   word0;
    logic [7:0] part;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus ();

    uart_rx_param dut (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .bus   (bus)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.data = d;
        e.ferr = fe;
        e.perr = pe;
        exp_q.push_back(e);
        push_cnt++;
    endtask

    // One frame on rx, starting at a negedge. glitch_bit puts a 25-clk low
    // pulse over the s=M sample of that data bit; ready_pulse raises rx_ready
    // for the single cycle in which the last stop bit is voted.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_val,
                              input int glitch_bit, input logic ready_pulse);
        $display("send frame 0x%02h par %0b stop %0b", d, par, stop_val);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == glitch_bit) begin
                wait_clk(203);
                rx = 1'b0;
                wait_clk(25);
                rx = d[i];
                wait_clk(BIT_CLK - 228);
            end else begin
                wait_clk(BIT_CLK);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clk(BIT_CLK);
`endif
        rx = stop_val;
        if (ready_pulse) begin
            wait_clk(252);
            bus.rx_ready = 1'b1;
            wait_clk(1);
            bus.rx_ready = 1'b0;
            wait_clk(BIT_CLK - 253);
        end else begin
            wait_clk(BIT_CLK);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_valid"}, int'(bus.rx_valid), 0);
        check({tag, "_rx_data"}, int'(bus.rx_data), 0);
        check({tag, "_frame_err"}, int'(bus.frame_err), 0);
        check({tag, "_parity_err"}, int'(bus.parity_err), 0);
        check({tag, "_overrun"}, int'(bus.overrun), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    // Monitor: a new word is on the bus when rx_valid rises or stays high
    // right after a handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.overrun) begin
                ovr_cnt++;
            end
            if (bus.rx_valid && (!mon_prev_valid || mon_prev_hs)) begin
                word_cnt++;
                $display("word 0x%02h frame_err %0b parity_err %0b", bus.rx_data, bus.frame_err, bus.parity_err);
                if (exp_q.size() == 0) begin
                    check("unexpected_word", int'(bus.rx_data), -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", int'(bus.rx_data), int'(mon_e.data));
                    check("word_frame_err", int'(bus.frame_err), int'(mon_e.ferr));
                    check("word_parity_err", int'(bus.parity_err), int'(mon_e.perr));
                end
            end
            mon_prev_valid = bus.rx_valid;
            mon_prev_hs    = bus.rx_valid && bus.rx_ready;
        end
    end

    initial begin
        bus.rx_ready = 1'b0;
        #2 reset = 1'b0;
        wait_clk(3);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        wait_clk(20);

        // Word held until rx_ready, then rx_valid drops on the next clk.
        push(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, -1, 1'b0);
        wait_clk(600);
        #1;
        check("hold_valid", int'(bus.rx_valid), 1);
        check("hold_data", int'(bus.rx_data), 'h55);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        wait_clk(1);
        bus.rx_ready = 1'b0;
        #1;
        check("ack_valid_drop", int'(bus.rx_valid), 0);
        bus.rx_ready = 1'b1;
        wait_clk(100);

        // False start: 100 clk low pulse.
        word0 = word_cnt;
        rx = 1'b0;
        wait_clk(50);
        #1;
        check("false_start_busy", int'(bus.busy), 1);
        wait_clk(50);
        rx = 1'b1;
        wait_clk(400);
        #1;
        check("false_start_idle", int'(bus.busy), 0);
        check("false_start_no_word", word_cnt - word0, 0);

        // Framing error with a break; receiver waits for the line to rise.
        push(8'hA3, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b0, -1, 1'b0);
        wait_clk(1600);
        #1;
        check("break_busy", int'(bus.busy), 1);
        rx = 1'b1;
        wait_clk(100);
        #1;
        check("break_released", int'(bus.busy), 0);
        push(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
        wait_clk(100);

        // Overrun: second frame dropped while the first is held.
        bus.rx_ready = 1'b0;
        ovr0 = ovr_cnt;
        push(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1, -1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, -1, 1'b0);
        wait_clk(100);
        #1;
        check("overrun_held_data", int'(bus.rx_data), 'h12);
        check("overrun_pulses", ovr_cnt - ovr0, 1);
        @(negedge clk);
        bus.rx_ready = 1'b1;
        wait_clk(1);
        bus.rx_ready = 1'b0;
        wait_clk(50);

        // rx_ready in the completion cycle: new word replaces the held one.
        ovr0 = ovr_cnt;
        push(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1, -1, 1'b0);
        push(8'h34, 1'b0, 1'b0);
        send_frame(8'h34, 1'b1, 1'b1, -1, 1'b1);
        wait_clk(100);
        #1;
        check("ready_at_done_data", int'(bus.rx_data), 'h34);
        check("ready_at_done_valid", int'(bus.rx_valid), 1);
        check("ready_at_done_no_overrun", ovr_cnt - ovr0, 0);
        bus.rx_ready = 1'b1;
        wait_clk(50);

        // Parity: 0x07 has three ones, so even parity needs a 1.
        push(8'h07, 1'b0, PE_07_BAD);
        send_frame(8'h07, 1'b0, 1'b1, -1, 1'b0);
        push(8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, -1, 1'b0);
        wait_clk(100);

        // Single low sample inside data bit 2 is outvoted.
        bus.rx_ready = 1'b0;
        push(8'hFF, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 2, 1'b0);
        wait_clk(100);
        #1;
        check("glitch_data", int'(bus.rx_data), 'hFF);

        // Reset in the middle of data bit 3 of 0xC4.
        part = 8'hC4;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 3; i++) begin
            rx = part[i];
            wait_clk(BIT_CLK);
        end
        rx = part[3];
        wait_clk(200);
        reset = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        rx = 1'b1;
        wait_clk(5);
        reset = 1'b1;
        wait_clk(50);
        bus.rx_ready = 1'b1;
        push(8'hC4, 1'b0, 1'b0);
        send_frame(8'hC4, 1'b1, 1'b1, -1, 1'b0);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        wait_clk(2);
        check("scoreboard_drained", exp_q.size(), 0);
        check("word_count", word_cnt, push_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the fixed 8N1 receiver. It runs from a single system clock with an internal sample-tick divider, so no separate sample clock is needed. Adds configurable data width, oversampling ratio and stop-bit count, 3-sample majority voting, false-start rejection, framing/overrun detection and a valid/ready output handshake. Sits between the pad-side rx line and the UART register/FIFO layer.

Parameters:
CLK_DIV, 25, clk cycles per sample tick (≥2)
OVERSAMPLE, 16, sample ticks per bit (even, ≥8)
DATA_BITS, 8, data bits per frame (5..9), LSB first
STOP_BITS, 1, stop bits checked (1 or 2)
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (used only with UART_RX_PARITY_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  DATA_BITS  received word
rx_valid  output  1  rx_data/frame_err/parity_err valid
rx_ready  input  1  consumer accepts word when rx_valid & rx_ready at clk edge
frame_err  output  1  a stop bit of the current word sampled 0
parity_err  output  1  parity mismatch on the current word
overrun  output  1  one-cycle pulse: a frame completed while the previous word was still held
busy  output  1  receiver not in IDLE

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, counters 0, sync flops 1; rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0. Reset mid-frame discards the partial frame.
- rx passes a 2-FF synchronizer (reset value 1); all decisions use the synchronized value rx_s.
- Divider: counts 0..CLK_DIV-1, tick at CLK_DIV-1; cleared on start detect. Sample counter s: 0..OVERSAMPLE-1 per bit, advances on tick, wraps to 0 at bit end.
- Vote: with M=OVERSAMPLE/2, sample rx_s at s=M-1, M, M+1; bit value = majority of the three, decided at the s=M+1 tick.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s=0 -> START, divider and s cleared.
- START: vote=1 -> IDLE (false start, no outputs). Vote=0 -> DATA at the bit end.
- DATA: shift voted bits LSB-first, DATA_BITS bits -> PARITY (if enabled) else STOP.
- STOP: each of STOP_BITS voted; any 0 sets the frame's frame_err. At the vote of the last stop bit (not the bit end), the frame completes. Next state is IDLE if that vote=1, else BREAK.
- BREAK: wait for rx_s=1, then IDLE; no start detect while low.
- Completion (registered, outputs update 1 clk after the last-stop vote tick):
  - rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, frame_err and parity_err; rx_valid=1.
  - rx_valid=1 and rx_ready=0: new frame dropped, held word unchanged, overrun=1 for exactly one clk.
- Handshake: rx_valid=1 and rx_ready=1 with no completion -> rx_valid=0 next clk. rx_data and the error flags hold their value until the next load.
- busy=1 in every state except IDLE.

Optional Feature:
UART_RX_PARITY_EN: when defined, a PARITY state follows DATA. The voted bit is compared with the XOR of the data bits, inverted when PARITY_ODD=1. A mismatch sets parity_err with the word. When undefined, there is no PARITY state, the bit after the data is treated as the first stop bit, and parity_err is tied to 0.

Test Plan:
- Defaults (bit = 400 clk): frame 0x55 with 1 stop bit, rx_ready=0 -> rx_valid=1, rx_data=0x55, frame_err=0, held until rx_ready pulse, then rx_valid=0 the next clk.
- rx low for 100 clk then high -> busy pulses; no rx_valid; back in IDLE.
- Frame 0xA3 with stop bit 0, line held low 2000 clk -> rx_data=0xA3, frame_err=1; no further frame until the line returns high; next frame 0x3C has frame_err=0.
- Back-to-back frames 0x12, 0x34 with rx_ready=0 -> rx_data stays 0x12, single overrun pulse; repeat with rx_ready=1 at the second completion -> rx_data=0x34, no overrun.
- UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0. Without the macro, parity_err is always 0.
- 1-tick low glitch at s=M of data bit 2 of 0xFF -> rx_data=0xFF. Reset asserted during data bit 3 -> all outputs 0 at once; next frame 0xC4 is received correctly.
